// File: rtl/apb_arbiter_m2.sv
// Two-master APB3 arbiter: round-robin grant onto one shared downstream APB bus,
// one transfer at a time, with an optional per-transfer PREADY timeout that returns PSLVERR.
module apb_arbiter_m2 #(
  parameter int WIDTH_PAD = 32,
  parameter int WIDTH_PDA = 32,
  parameter int TIMEOUT   = 256
) (
  input  logic                 PRESETn,
  input  logic                 PCLK,
  input  logic                 M0_PSEL,
  input  logic                 M0_PENABLE,
  input  logic [WIDTH_PAD-1:0] M0_PADDR,
  input  logic                 M0_PWRITE,
  input  logic [WIDTH_PDA-1:0] M0_PWDATA,
  output logic [WIDTH_PDA-1:0] M0_PRDATA,
  output logic                 M0_PREADY,
  output logic                 M0_PSLVERR,
  input  logic                 M1_PSEL,
  input  logic                 M1_PENABLE,
  input  logic [WIDTH_PAD-1:0] M1_PADDR,
  input  logic                 M1_PWRITE,
  input  logic [WIDTH_PDA-1:0] M1_PWDATA,
  output logic [WIDTH_PDA-1:0] M1_PRDATA,
  output logic                 M1_PREADY,
  output logic                 M1_PSLVERR,
  output logic                 S_PSEL,
  output logic                 S_PENABLE,
  output logic [WIDTH_PAD-1:0] S_PADDR,
  output logic                 S_PWRITE,
  output logic [WIDTH_PDA-1:0] S_PWDATA,
  input  logic [WIDTH_PDA-1:0] S_PRDATA,
  input  logic                 S_PREADY,
  input  logic                 S_PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t        state_q, state_d;
  // The current grant is also the last grant: it only changes when a new grant is issued.
  logic          grant_q, grant_d;
  logic [TW-1:0] timer_q;
  logic          timeout;
  logic          done;

  // The master enables are not needed: PSEL alone marks a pending request.
  logic unused_penable;
  assign unused_penable = M0_PENABLE ^ M1_PENABLE;

  assign done    = (state_q == ACCESS) && S_PREADY;
  assign timeout = (TIMEOUT != 0) && (state_q == ACCESS) && !S_PREADY && (timer_q == T_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (M0_PSEL || M1_PSEL) begin
          state_d = SETUP;
          grant_d = (M0_PSEL && M1_PSEL) ? ~grant_q : M1_PSEL;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (S_PREADY || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_q == SETUP)
        timer_q <= '0;
      else if (state_q == ACCESS && !S_PREADY && timer_q != '1)
        timer_q <= timer_q + 1'b1;
    end
  end

  always_comb begin
    S_PSEL     = (state_q != IDLE);
    S_PENABLE  = (state_q == ACCESS);
    S_PADDR    = '0;
    S_PWRITE   = 1'b0;
    S_PWDATA   = '0;
    M0_PREADY  = 1'b0;
    M0_PRDATA  = '0;
    M0_PSLVERR = 1'b0;
    M1_PREADY  = 1'b0;
    M1_PRDATA  = '0;
    M1_PSLVERR = 1'b0;
    if (state_q != IDLE) begin
      S_PADDR  = grant_q ? M1_PADDR  : M0_PADDR;
      S_PWRITE = grant_q ? M1_PWRITE : M0_PWRITE;
      S_PWDATA = grant_q ? M1_PWDATA : M0_PWDATA;
    end
    // A timeout completes the transfer with an error and no read data.
    if (grant_q) begin
      M1_PREADY  = done || timeout;
      M1_PRDATA  = done ? S_PRDATA : '0;
      M1_PSLVERR = done ? S_PSLVERR : timeout;
    end else begin
      M0_PREADY  = done || timeout;
      M0_PRDATA  = done ? S_PRDATA : '0;
      M0_PSLVERR = done ? S_PSLVERR : timeout;
    end
  end

endmodule

// File: tb/tb_apb_arbiter_m2.sv
// Directed bench for apb_arbiter_m2: reset, latency, round-robin, timeout, error routing,
// and reset during an access.
module tb_apb_arbiter_m2;

  logic        PRESETn, PCLK;
  logic        M0_PSEL, M0_PENABLE, M0_PWRITE;
  logic [31:0] M0_PADDR, M0_PWDATA, M0_PRDATA;
  logic        M0_PREADY, M0_PSLVERR;
  logic        M1_PSEL, M1_PENABLE, M1_PWRITE;
  logic [31:0] M1_PADDR, M1_PWDATA, M1_PRDATA;
  logic        M1_PREADY, M1_PSLVERR;
  logic        S_PSEL, S_PENABLE, S_PWRITE;
  logic [31:0] S_PADDR, S_PWDATA, S_PRDATA;
  logic        S_PREADY, S_PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_arbiter_m2 #(.WIDTH_PAD(32), .WIDTH_PDA(32), .TIMEOUT(4)) dut (
    .PRESETn(PRESETn), .PCLK(PCLK),
    .M0_PSEL(M0_PSEL), .M0_PENABLE(M0_PENABLE), .M0_PADDR(M0_PADDR), .M0_PWRITE(M0_PWRITE),
    .M0_PWDATA(M0_PWDATA), .M0_PRDATA(M0_PRDATA), .M0_PREADY(M0_PREADY), .M0_PSLVERR(M0_PSLVERR),
    .M1_PSEL(M1_PSEL), .M1_PENABLE(M1_PENABLE), .M1_PADDR(M1_PADDR), .M1_PWRITE(M1_PWRITE),
    .M1_PWDATA(M1_PWDATA), .M1_PRDATA(M1_PRDATA), .M1_PREADY(M1_PREADY), .M1_PSLVERR(M1_PSLVERR),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave read data is a fixed function of the address so routing errors are visible.
  assign S_PRDATA = S_PADDR ^ 32'h5A5A_0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Hold reset for two cycles, then release right after an edge: that cycle is cycle 0.
  task automatic do_reset();
    cyc(1);
    PRESETn = 1'b0;
    cyc(2);
    PRESETn = 1'b1;
  endtask

  initial begin
    PRESETn = 1'b1;
    M0_PSEL = 0; M0_PENABLE = 0; M0_PADDR = 0; M0_PWRITE = 0; M0_PWDATA = 0;
    M1_PSEL = 0; M1_PENABLE = 0; M1_PADDR = 0; M1_PWRITE = 0; M1_PWDATA = 0;
    S_PREADY = 1'b1; S_PSLVERR = 1'b0;

    // Reset with both masters requesting: all outputs quiet.
    M0_PSEL = 1; M0_PADDR = 32'h0001_0004; M0_PWRITE = 1; M0_PWDATA = 32'hDEAD_BEEF;
    M1_PSEL = 1; M1_PADDR = 32'h0000_0200; M1_PWRITE = 0; M1_PWDATA = 32'h1111_2222;
    cyc(1);
    PRESETn = 1'b0;
    #2;
    check("rst_s_psel",   S_PSEL,    0);
    check("rst_s_pen",    S_PENABLE, 0);
    check("rst_s_paddr",  S_PADDR,   0);
    check("rst_m0_ready", M0_PREADY, 0);
    check("rst_m1_ready", M1_PREADY, 0);
    check("rst_m0_rdata", M0_PRDATA, 0);
    check("rst_m0_err",   M0_PSLVERR, 0);
    cyc(2);
    PRESETn = 1'b1;                       // cycle 0
    #1;
    check("c0_s_psel", S_PSEL, 0);
    cyc(1); #1;                           // cycle 1: SETUP for M0 write
    check("w_setup_psel",  S_PSEL,    1);
    check("w_setup_pen",   S_PENABLE, 0);
    check("w_setup_paddr", S_PADDR,   32'h0001_0004);
    check("w_setup_pwdat", S_PWDATA,  32'hDEAD_BEEF);
    check("w_setup_pwr",   S_PWRITE,  1);
    check("w_setup_m0rdy", M0_PREADY, 0);
    M0_PENABLE = 1;
    cyc(1); #1;                           // cycle 2: ACCESS, completes
    check("w_acc_pen",    S_PENABLE, 1);
    check("w_acc_m0rdy",  M0_PREADY, 1);
    check("w_acc_m0err",  M0_PSLVERR, 0);
    check("w_acc_m1rdy",  M1_PREADY, 0);
    cyc(1);                               // cycle 3: IDLE, M0 done
    M0_PSEL = 0; M0_PENABLE = 0;
    #1;
    check("w_idle_psel",  S_PSEL,  0);
    check("w_idle_paddr", S_PADDR, 0);
    cyc(1); #1;                           // cycle 4: M1 read setup
    check("r1_setup_paddr", S_PADDR,  32'h0000_0200);
    check("r1_setup_pwr",   S_PWRITE, 0);
    cyc(1); #1;                           // cycle 5: M1 completes
    check("r1_m1rdy",   M1_PREADY, 1);
    check("r1_m1rdata", M1_PRDATA, 32'h5A5A_0200);
    check("r1_m0rdy",   M0_PREADY, 0);
    cyc(1);
    M1_PSEL = 0;

    // Round robin with both masters reading continuously.
    M0_PSEL = 1; M0_PADDR = 32'h0000_0100; M0_PWRITE = 0;
    M1_PSEL = 1; M1_PADDR = 32'h0000_0200; M1_PWRITE = 0;
    do_reset();                           // cycle 0
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_addr;
      exp_addr = (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      cyc(1); #1;                         // SETUP
      check($sformatf("rr%0d_paddr", k), S_PADDR, exp_addr);
      check($sformatf("rr%0d_m1rdy_setup", k), M1_PREADY, 0);
      cyc(1); #1;                         // ACCESS
      if (k % 2 == 0) begin
        check($sformatf("rr%0d_m0rdy", k),   M0_PREADY, 1);
        check($sformatf("rr%0d_m0rdata", k), M0_PRDATA, 32'h5A5A_0100);
        check($sformatf("rr%0d_m1rdy", k),   M1_PREADY, 0);
        check($sformatf("rr%0d_m1rdata", k), M1_PRDATA, 0);
      end else begin
        check($sformatf("rr%0d_m1rdy", k),   M1_PREADY, 1);
        check($sformatf("rr%0d_m1rdata", k), M1_PRDATA, 32'h5A5A_0200);
        check($sformatf("rr%0d_m0rdy", k),   M0_PREADY, 0);
        check($sformatf("rr%0d_m0rdata", k), M0_PRDATA, 0);
      end
      cyc(1); #1;                         // mandatory IDLE
      check($sformatf("rr%0d_idle", k), S_PSEL, 0);
    end
    cyc(1);
    M0_PSEL = 0; M1_PSEL = 0;

    // Timeout with TIMEOUT=4: error on the fourth ACCESS cycle, no read data.
    M0_PSEL = 1; M0_PADDR = 32'h0000_0300;
    S_PREADY = 0;
    do_reset();
    cyc(1);                               // cycle 1 SETUP
    for (int c = 2; c <= 4; c++) begin
      cyc(1); #1;
      check($sformatf("to_c%0d_m0rdy", c), M0_PREADY, 0);
      check($sformatf("to_c%0d_pen", c),   S_PENABLE, 1);
    end
    cyc(1); #1;                           // cycle 5
    check("to_m0rdy",   M0_PREADY,  1);
    check("to_m0err",   M0_PSLVERR, 1);
    check("to_m0rdata", M0_PRDATA,  0);
    check("to_m1rdy",   M1_PREADY,  0);
    cyc(1);
    M0_PSEL = 0;
    #1;
    check("to_after_psel", S_PSEL, 0);
    S_PREADY = 1;

    // Slave error on an M1 read is returned to M1 only.
    M1_PSEL = 1; M1_PADDR = 32'h0000_0200;
    S_PSLVERR = 1;
    do_reset();
    cyc(2); #1;                           // cycle 2 ACCESS
    check("err_m1rdy",   M1_PREADY,  1);
    check("err_m1err",   M1_PSLVERR, 1);
    check("err_m1rdata", M1_PRDATA,  32'h5A5A_0200);
    check("err_m0rdy",   M0_PREADY,  0);
    check("err_m0err",   M0_PSLVERR, 0);
    check("err_m0rdata", M0_PRDATA,  0);
    cyc(1);
    M1_PSEL = 0; S_PSLVERR = 0;

    // Reset during a stalled access aborts silently; M0 wins the first tie afterwards.
    M1_PSEL = 1; M1_PADDR = 32'h0000_0200;
    S_PREADY = 0;
    do_reset();
    cyc(2); #1;                           // cycle 2 ACCESS for M1
    check("ra_pen", S_PENABLE, 1);
    cyc(1);
    PRESETn = 1'b0;
    #1;
    check("ra_psel",  S_PSEL,    0);
    check("ra_pen0",  S_PENABLE, 0);
    check("ra_m1rdy", M1_PREADY, 0);
    M0_PSEL = 1; M0_PADDR = 32'h0000_0100;
    S_PREADY = 1;
    cyc(1);
    PRESETn = 1'b1;                       // cycle 0, both requesting
    cyc(1); #1;
    check("ra_regrant_psel",  S_PSEL,  1);
    check("ra_regrant_paddr", S_PADDR, 32'h0000_0100);
    cyc(1); #1;
    check("ra_regrant_m0rdy", M0_PREADY, 1);
    check("ra_regrant_m1rdy", M1_PREADY, 0);
    cyc(1);
    M0_PSEL = 0; M1_PSEL = 0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
